// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline stage.
// Holds ALU operation codes, main-decoder class encodings and funct3 values,
// plus the packed control record that travels from ID into EX.
package id_ex_stage_pkg;

   // ALU operation codes driven to the execute unit
   localparam logic [3:0] ALU_AND     = 4'b0000;
   localparam logic [3:0] ALU_OR      = 4'b0001;
   localparam logic [3:0] ALU_ADD     = 4'b0010;
   localparam logic [3:0] ALU_SUB     = 4'b0110;
   localparam logic [3:0] ALU_INVALID = 4'b1111;

   // Main-decoder instruction class
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_ITYPE = 2'b11
   } alu_op_e;

   // funct3 values the ALU decoder distinguishes
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_OR      = 3'b110;

   // Control fields registered between ID and EX
   typedef struct packed {
      logic       valid;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       alu_src;
      alu_op_e    alu_op;
      logic [2:0] funct3;
      logic       funct7_5;
      logic       reg_write;
   } ex_ctrl_t;

   // Bubble: everything zero, which also decodes as ALU_OP class 00 (add)
   localparam ex_ctrl_t CTRL_BUBBLE = '0;

   // A writeback source forwards only when it writes a non-x0 register
   // whose index matches the consumer's source index.
   function automatic logic fwd_hit(input logic we, input logic [4:0] src_rd,
                                    input logic [4:0] rs);
      return we && (src_rd != 5'd0) && (src_rd == rs);
   endfunction

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// Purpose: combinational ALU operation decode from class, funct3 and funct7[5].
// Latency: zero (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: alu_op (class), funct3, funct7_5 in; alu_operation (4-bit code) out.
module alu_control
   import id_ex_stage_pkg::*;
(
   input  alu_op_e    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_operation
);

   always_comb begin
      alu_operation = ALU_INVALID;
      case (alu_op)
         ALUOP_ADD: alu_operation = ALU_ADD;
         ALUOP_SUB: alu_operation = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct3)
               F3_ADD_SUB: alu_operation = funct7_5 ? ALU_SUB : ALU_ADD;
               F3_AND:     alu_operation = ALU_AND;
               F3_OR:      alu_operation = ALU_OR;
               default:    alu_operation = ALU_INVALID;
            endcase
         end
         ALUOP_ITYPE: begin
            // Immediate forms have no subtract; funct7[5] is ignored here.
            case (funct3)
               F3_ADD_SUB: alu_operation = ALU_ADD;
               F3_AND:     alu_operation = ALU_AND;
               F3_OR:      alu_operation = ALU_OR;
               default:    alu_operation = ALU_INVALID;
            endcase
         end
         default: alu_operation = ALU_INVALID;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// Purpose: ID/EX pipeline register with EX-side operand forwarding and ALU decode.
// Latency: 1 cycle ID -> EX; forwarding and decode are combinational after the register.
// Backpressure: STALL holds all state, FLUSH loads a bubble, RESET overrides both.
// Ports: ID_* decode inputs; EXMEM_*/MEMWB_* writeback sources for forwarding;
//        A/B operands, ALU_OPERATION, EX_STORE_DATA and EX_RD/EX_REG_WRITE/EX_VALID out.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             STALL,
   input  logic             FLUSH,
   input  logic             ID_VALID,
   input  logic [WIDTH-1:0] ID_RS1_DATA,
   input  logic [WIDTH-1:0] ID_RS2_DATA,
   input  logic [WIDTH-1:0] ID_IMM,
   input  logic [4:0]       ID_RS1,
   input  logic [4:0]       ID_RS2,
   input  logic [4:0]       ID_RD,
   input  logic             ID_ALU_SRC,
   input  logic [1:0]       ID_ALU_OP,
   input  logic [2:0]       ID_FUNCT3,
   input  logic             ID_FUNCT7_5,
   input  logic             ID_REG_WRITE,
   input  logic [4:0]       EXMEM_RD,
   input  logic             EXMEM_REG_WRITE,
   input  logic [WIDTH-1:0] EXMEM_RESULT,
   input  logic [4:0]       MEMWB_RD,
   input  logic             MEMWB_REG_WRITE,
   input  logic [WIDTH-1:0] MEMWB_RESULT,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [3:0]       ALU_OPERATION,
   output logic [WIDTH-1:0] EX_STORE_DATA,
   output logic [4:0]       EX_RD,
   output logic             EX_REG_WRITE,
   output logic             EX_VALID
);

   ex_ctrl_t         ctrl_q;
   logic [WIDTH-1:0] rs1_data_q;
   logic [WIDTH-1:0] rs2_data_q;
   logic [WIDTH-1:0] imm_q;

   logic [WIDTH-1:0] rs1_fwd;
   logic [WIDTH-1:0] rs2_fwd;

   // Reset and flush produce the same bubble; stall simply skips the load.
   always_ff @(posedge CLK) begin
      if (RESET || FLUSH) begin
         ctrl_q     <= CTRL_BUBBLE;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
      end else if (!STALL) begin
         ctrl_q.valid     <= ID_VALID;
         ctrl_q.rs1       <= ID_RS1;
         ctrl_q.rs2       <= ID_RS2;
         ctrl_q.rd        <= ID_RD;
         ctrl_q.alu_src   <= ID_ALU_SRC;
         ctrl_q.alu_op    <= alu_op_e'(ID_ALU_OP);
         ctrl_q.funct3    <= ID_FUNCT3;
         ctrl_q.funct7_5  <= ID_FUNCT7_5;
         ctrl_q.reg_write <= ID_REG_WRITE;
         rs1_data_q       <= ID_RS1_DATA;
         rs2_data_q       <= ID_RS2_DATA;
         imm_q            <= ID_IMM;
      end
   end

   // Forwarding compares against the registered indices: the instruction now in EX
   // is the consumer. EX/MEM is younger than MEM/WB, so it wins on a double match.
   always_comb begin
      rs1_fwd = rs1_data_q;
      if (fwd_hit(EXMEM_REG_WRITE, EXMEM_RD, ctrl_q.rs1)) begin
         rs1_fwd = EXMEM_RESULT;
      end else if (fwd_hit(MEMWB_REG_WRITE, MEMWB_RD, ctrl_q.rs1)) begin
         rs1_fwd = MEMWB_RESULT;
      end

      rs2_fwd = rs2_data_q;
      if (fwd_hit(EXMEM_REG_WRITE, EXMEM_RD, ctrl_q.rs2)) begin
         rs2_fwd = EXMEM_RESULT;
      end else if (fwd_hit(MEMWB_REG_WRITE, MEMWB_RD, ctrl_q.rs2)) begin
         rs2_fwd = MEMWB_RESULT;
      end
   end

   assign A             = rs1_fwd;
   assign B             = ctrl_q.alu_src ? imm_q : rs2_fwd;
   // Stores always need the real rs2 value, even when B carries the immediate.
   assign EX_STORE_DATA = rs2_fwd;
   assign EX_RD         = ctrl_q.rd;
   assign EX_VALID      = ctrl_q.valid;
   assign EX_REG_WRITE  = ctrl_q.reg_write & ctrl_q.valid;

   alu_control u_alu_control (
      .alu_op        (ctrl_q.alu_op),
      .funct3        (ctrl_q.funct3),
      .funct7_5      (ctrl_q.funct7_5),
      .alu_operation (ALU_OPERATION)
   );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: the driver sets inputs on the falling edge and
// queues hand-computed outputs; the monitor pops one entry after each rising edge.
module tb_id_ex_stage;

   localparam int W = 32;

   logic         CLK = 1'b0;
   logic         RESET, STALL, FLUSH, ID_VALID;
   logic [W-1:0] ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
   logic [4:0]   ID_RS1, ID_RS2, ID_RD;
   logic         ID_ALU_SRC;
   logic [1:0]   ID_ALU_OP;
   logic [2:0]   ID_FUNCT3;
   logic         ID_FUNCT7_5, ID_REG_WRITE;
   logic [4:0]   EXMEM_RD, MEMWB_RD;
   logic         EXMEM_REG_WRITE, MEMWB_REG_WRITE;
   logic [W-1:0] EXMEM_RESULT, MEMWB_RESULT;
   logic [W-1:0] A, B, EX_STORE_DATA;
   logic [3:0]   ALU_OPERATION;
   logic [4:0]   EX_RD;
   logic         EX_REG_WRITE, EX_VALID;

   id_ex_stage #(.WIDTH(W)) dut (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .ID_VALID(ID_VALID),
      .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD), .ID_ALU_SRC(ID_ALU_SRC),
      .ID_ALU_OP(ID_ALU_OP), .ID_FUNCT3(ID_FUNCT3), .ID_FUNCT7_5(ID_FUNCT7_5),
      .ID_REG_WRITE(ID_REG_WRITE),
      .EXMEM_RD(EXMEM_RD), .EXMEM_REG_WRITE(EXMEM_REG_WRITE), .EXMEM_RESULT(EXMEM_RESULT),
      .MEMWB_RD(MEMWB_RD), .MEMWB_REG_WRITE(MEMWB_REG_WRITE), .MEMWB_RESULT(MEMWB_RESULT),
      .A(A), .B(B), .ALU_OPERATION(ALU_OPERATION), .EX_STORE_DATA(EX_STORE_DATA),
      .EX_RD(EX_RD), .EX_REG_WRITE(EX_REG_WRITE), .EX_VALID(EX_VALID)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string        name;
      logic [W-1:0] a, b, sd;
      logic [3:0]   op;
      logic [4:0]   rd;
      logic         rw, v;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (A !== e.a || B !== e.b || EX_STORE_DATA !== e.sd || ALU_OPERATION !== e.op ||
                EX_RD !== e.rd || EX_REG_WRITE !== e.rw || EX_VALID !== e.v) begin
               miscompares++;
               $display("FAIL %s: got A=%h B=%h SD=%h OP=%b RD=%0d RW=%b V=%b, want A=%h B=%h SD=%h OP=%b RD=%0d RW=%b V=%b",
                        e.name, A, B, EX_STORE_DATA, ALU_OPERATION, EX_RD, EX_REG_WRITE, EX_VALID,
                        e.a, e.b, e.sd, e.op, e.rd, e.rw, e.v);
            end
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic idle();
      RESET = 0; STALL = 0; FLUSH = 0; ID_VALID = 0;
      ID_RS1_DATA = '0; ID_RS2_DATA = '0; ID_IMM = '0;
      ID_RS1 = 0; ID_RS2 = 0; ID_RD = 0; ID_ALU_SRC = 0; ID_ALU_OP = 2'b00;
      ID_FUNCT3 = 3'b000; ID_FUNCT7_5 = 0; ID_REG_WRITE = 0;
      EXMEM_RD = 0; EXMEM_REG_WRITE = 0; EXMEM_RESULT = '0;
      MEMWB_RD = 0; MEMWB_REG_WRITE = 0; MEMWB_RESULT = '0;
   endtask

   task automatic load(input logic [4:0] rs1, input logic [W-1:0] d1,
                       input logic [4:0] rs2, input logic [W-1:0] d2,
                       input logic [4:0] rd, input logic [1:0] aop,
                       input logic [2:0] f3, input logic f7, input logic we);
      ID_VALID = 1; ID_RS1 = rs1; ID_RS1_DATA = d1; ID_RS2 = rs2; ID_RS2_DATA = d2;
      ID_RD = rd; ID_ALU_OP = aop; ID_FUNCT3 = f3; ID_FUNCT7_5 = f7; ID_REG_WRITE = we;
      ID_ALU_SRC = 0; ID_IMM = '0;
   endtask

   // Queue the outputs expected after the next rising edge, then move to the next falling edge.
   task automatic expect_out(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] sd, input logic [3:0] op, input logic [4:0] rd,
                             input logic rw, input logic v);
      exp_t e;
      e.name = name; e.a = a; e.b = b; e.sd = sd; e.op = op; e.rd = rd; e.rw = rw; e.v = v;
      q.push_back(e);
      @(negedge CLK);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle();
      RESET = 1;
      expect_out("reset", 0, 0, 0, 4'b0010, 0, 0, 0);

      idle();
      load(1, 32'd5, 2, 32'd3, 3, 2'b10, 3'b000, 1, 1);
      expect_out("rtype_sub", 32'd5, 32'd3, 32'd3, 4'b0110, 3, 1, 1);

      load(1, 32'd7, 2, 32'd9, 5, 2'b10, 3'b000, 0, 1);
      expect_out("rtype_add", 32'd7, 32'd9, 32'd9, 4'b0010, 5, 1, 1);

      load(4, 32'h11, 6, 32'h22, 7, 2'b10, 3'b111, 0, 1);
      EXMEM_RD = 4; EXMEM_REG_WRITE = 1; EXMEM_RESULT = 32'hAA;
      MEMWB_RD = 4; MEMWB_REG_WRITE = 1; MEMWB_RESULT = 32'hBB;
      expect_out("fwd_exmem_prio", 32'hAA, 32'h22, 32'h22, 4'b0000, 7, 1, 1);

      EXMEM_REG_WRITE = 0;
      expect_out("fwd_memwb", 32'hBB, 32'h22, 32'h22, 4'b0000, 7, 1, 1);

      idle();
      load(8, 32'd1, 9, 32'd2, 10, 2'b11, 3'b110, 0, 0);
      EXMEM_RD = 8; EXMEM_REG_WRITE = 0; EXMEM_RESULT = 32'h44;
      MEMWB_RD = 9; MEMWB_REG_WRITE = 1; MEMWB_RESULT = 32'h33;
      expect_out("fwd_rs2_memwb_nowrite", 32'd1, 32'h33, 32'h33, 4'b0001, 10, 0, 1);

      idle();
      load(0, 32'd0, 0, 32'd0, 1, 2'b00, 3'b000, 0, 1);
      EXMEM_RD = 0; EXMEM_REG_WRITE = 1; EXMEM_RESULT = 32'hFF;
      MEMWB_RD = 0; MEMWB_REG_WRITE = 1; MEMWB_RESULT = 32'hEE;
      expect_out("x0_no_fwd", 32'd0, 32'd0, 32'd0, 4'b0010, 1, 1, 1);

      idle();
      load(3, 32'h10, 5, 32'h55, 6, 2'b11, 3'b111, 0, 1);
      ID_ALU_SRC = 1; ID_IMM = 32'hFFFF_FFF0;
      EXMEM_RD = 5; EXMEM_REG_WRITE = 1; EXMEM_RESULT = 32'h66;
      expect_out("itype_imm", 32'h10, 32'hFFFF_FFF0, 32'h66, 4'b0000, 6, 1, 1);

      // Hold for three cycles while the decode inputs keep changing.
      STALL = 1;
      for (int i = 0; i < 3; i++) begin
         load(5'(i + 11), W'(32'h100 + i), 5'(i + 20), W'(32'h200 + i), 5'(i + 1),
              2'b01, 3'(i), 1, 0);
         ID_ALU_SRC = 0;
         expect_out("stall_hold", 32'h10, 32'hFFFF_FFF0, 32'h66, 4'b0000, 6, 1, 1);
      end

      FLUSH = 1;
      expect_out("stall_flush", 0, 0, 0, 4'b0010, 0, 0, 0);

      idle();
      load(1, 32'hA, 2, 32'hB, 2, 2'b10, 3'b010, 0, 1);
      expect_out("rtype_invalid_f3", 32'hA, 32'hB, 32'hB, 4'b1111, 2, 1, 1);

      load(1, 32'hA, 2, 32'hB, 2, 2'b11, 3'b001, 0, 1);
      expect_out("itype_invalid_f3", 32'hA, 32'hB, 32'hB, 4'b1111, 2, 1, 1);

      load(1, 32'hA, 2, 32'hB, 2, 2'b10, 3'b110, 0, 1);
      expect_out("rtype_or", 32'hA, 32'hB, 32'hB, 4'b0001, 2, 1, 1);

      load(1, 32'hA, 2, 32'hB, 2, 2'b11, 3'b000, 1, 1);
      expect_out("itype_add_ignores_f7", 32'hA, 32'hB, 32'hB, 4'b0010, 2, 1, 1);

      load(1, 32'hA, 2, 32'hB, 2, 2'b01, 3'b111, 0, 1);
      expect_out("branch_sub", 32'hA, 32'hB, 32'hB, 4'b0110, 2, 1, 1);

      STALL = 1; RESET = 1;
      expect_out("reset_mid_stall", 0, 0, 0, 4'b0010, 0, 0, 0);

      // Forwarding source active during reset: rs1/rs2 are 0 so nothing forwards.
      RESET = 1; STALL = 0;
      EXMEM_RD = 3; EXMEM_REG_WRITE = 1; EXMEM_RESULT = 32'h77;
      expect_out("reset_fwd_blocked", 0, 0, 0, 4'b0010, 0, 0, 0);

      idle();
      load(12, 32'h1234, 13, 32'h5678, 14, 2'b10, 3'b000, 0, 1);
      expect_out("load_before_flush", 32'h1234, 32'h5678, 32'h5678, 4'b0010, 14, 1, 1);

      FLUSH = 1;
      expect_out("flush", 0, 0, 0, 4'b0010, 0, 0, 0);

      idle();
      load(7, 32'hCAFE, 8, 32'hBEEF, 9, 2'b10, 3'b000, 0, 1);
      ID_ALU_SRC = 1; ID_IMM = 32'h0000_0004;
      expect_out("itype_store_data", 32'hCAFE, 32'h4, 32'hBEEF, 4'b0010, 9, 1, 1);

      // Let the monitor drain, bounded.
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width.
REQ-002 SHALL have ports (name direction width meaning):
- CLK in 1: single clock, rising edge.
- RESET in 1: synchronous, active-high reset.
- STALL in 1: hold stage contents.
- FLUSH in 1: load bubble.
- ID_VALID in 1: decode slot holds an instruction.
- ID_RS1_DATA, ID_RS2_DATA in WIDTH: register-file read data.
- ID_IMM in WIDTH: sign-extended immediate.
- ID_RS1, ID_RS2, ID_RD in 5: register indices.
- ID_ALU_SRC in 1: 1 = B takes immediate.
- ID_ALU_OP in 2: main-decoder class.
- ID_FUNCT3 in 3, ID_FUNCT7_5 in 1: instruction function fields.
- ID_REG_WRITE in 1: destination write enable.
- EXMEM_RD in 5, EXMEM_REG_WRITE in 1, EXMEM_RESULT in WIDTH: EX/MEM writeback source.
- MEMWB_RD in 5, MEMWB_REG_WRITE in 1, MEMWB_RESULT in WIDTH: MEM/WB writeback source.
- A, B out WIDTH: ALU operands.
- ALU_OPERATION out 4: ALU operation code.
- EX_STORE_DATA out WIDTH: forwarded rs2 value.
- EX_RD out 5, EX_REG_WRITE out 1, EX_VALID out 1: forwarded control.

Function
REQ-003 SHALL register all ID_* inputs on rising CLK; latency exactly 1 cycle, ID to EX.
REQ-004 SHALL apply priority RESET > FLUSH > STALL > load.
REQ-005 FLUSH SHALL load a bubble: valid 0, reg_write 0, rd 0, ALU op class 00, data fields 0.
REQ-006 STALL (no FLUSH) SHALL hold every register unchanged.
REQ-007 SHALL decode ALU_OPERATION combinationally from registered fields:
- ALU_OP 00 -> 0010 (add).
- ALU_OP 01 -> 0110 (sub).
- ALU_OP 10: funct3 000 with f7_5=0 -> 0010, with f7_5=1 -> 0110; 111 -> 0000; 110 -> 0001; other -> 1111.
- ALU_OP 11: funct3 000 -> 0010; 111 -> 0000; 110 -> 0001; other -> 1111.
REQ-008 SHALL select forwarded rs1 combinationally:
- EXMEM_RESULT if EXMEM_REG_WRITE and EXMEM_RD!=0 and EXMEM_RD==rs1.
- else MEMWB_RESULT if MEMWB_REG_WRITE and MEMWB_RD!=0 and MEMWB_RD==rs1.
- else registered RS1_DATA.
REQ-009 SHALL apply the same forwarding rule to rs2.
REQ-010 Register x0 SHALL never be forwarded.
REQ-011 A SHALL equal forwarded rs1.
REQ-012 B SHALL equal registered IMM when ALU_SRC=1, else forwarded rs2.
REQ-013 EX_STORE_DATA SHALL always equal forwarded rs2, independent of ALU_SRC.
REQ-014 EX_REG_WRITE SHALL equal registered reg_write AND registered valid.
REQ-015 Forwarding comparisons SHALL use registered rs indices, not ID_* indices.

Reset
REQ-016 On RESET high at a rising edge, all registers SHALL clear to the bubble state of REQ-005.
REQ-017 After reset: A=B=0, ALU_OPERATION=0010, EX_VALID=0, EX_REG_WRITE=0, EX_RD=0, EX_STORE_DATA=0.
- Exception: a forwarding source asserted during reset may drive A/B through REQ-008; rs=0 blocks it.
REQ-018 RESET mid-stall SHALL override STALL; the held instruction is discarded.

Structure
REQ-019 A shared package SHALL hold:
- ALU operation codes 0000/0001/0010/0110/1111.
- ALU_OP class encodings 00/01/10/11.
- the funct3 constants used in REQ-007.
REQ-020 ALU decoding SHALL be a sub-module named alu_control.
REQ-021 Forwarding muxes SHALL stay inline in id_ex_stage.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- Load R-type: rs1=1 data 5, rs2=2 data 3, ALU_OP 10, funct3 000, f7_5=1, no forwarding -> next cycle A=5, B=3, ALU_OPERATION=0110.
- Both sources match rs1=4: EXMEM 4/0xAA, MEMWB 4/0xBB -> A=0xAA. Drop EXMEM_REG_WRITE -> A=0xBB.
- EXMEM_RD=0 with write enable and result 0xFF, rs1=0 -> A=registered rs1 data (0).
- I-type ALU_SRC=1, IMM=0xFFFFFFF0, funct3 111 -> B=0xFFFFFFF0, ALU_OPERATION=0000; EX_STORE_DATA=forwarded rs2.
- STALL for 3 cycles while ID inputs change -> outputs unchanged. STALL and FLUSH together -> EX_VALID=0, EX_REG_WRITE=0.
- Invalid funct3 010 with ALU_OP 10 -> ALU_OPERATION=1111. RESET asserted -> bubble values of REQ-017 next cycle.
